rd_circ_buf_multi: RTL

- Multi-source circular-buffer read engine.
- Arbitrates read requests from NUM_SRCS clients, each naming a (flow, offset, size) in per-flow circular buffers of 2^BUF_PTR_W bytes.
- Splits a request that wraps the buffer end into two memory reads, then streams the concatenated, realigned bytes back on one shared output tagged with the source id.
- Generalises the single-client read-buffer path with configurable data width, client count and wrap realignment.

---
 rtl/rd_circ_buf_multi_if.sv | 59 +++++
 rtl/rd_circ_buf_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_circ_buf_multi_if.sv
// Signal bundle for rd_circ_buf_multi: client requests, memory request/response and output stream.
// slave is the engine's view; master is the clients/memory/consumer view.
interface rd_circ_buf_multi_if #(
    parameter int NUM_SRCS  = 2,
    parameter int DATA_W    = 512,
    parameter int BUF_PTR_W = 12,
    parameter int FLOW_ID_W = 8,
    parameter int SIZE_W    = 16,
    parameter int ADDR_W    = 64
);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PAD_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int SRC_W      = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    logic [NUM_SRCS-1:0]           src_req_val;
    logic [NUM_SRCS*FLOW_ID_W-1:0] src_req_flowid;
    logic [NUM_SRCS*BUF_PTR_W-1:0] src_req_offset;
    logic [NUM_SRCS*SIZE_W-1:0]    src_req_size;
    logic [NUM_SRCS-1:0]           src_req_rdy;

    logic              mem_req_val;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [SIZE_W-1:0] mem_req_size;
    logic              mem_req_rdy;

    logic              mem_resp_val;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_resp_last;
    logic              mem_resp_rdy;

    logic              out_data_val;
    logic [DATA_W-1:0] out_data;
    logic              out_data_last;
    logic [PAD_W-1:0]  out_data_padbytes;
    logic [SRC_W-1:0]  out_data_srcid;
    logic              out_data_rdy;

    modport slave (
        input  src_req_val, src_req_flowid, src_req_offset, src_req_size,
        output src_req_rdy,
        output mem_req_val, mem_req_addr, mem_req_size,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_data, mem_resp_last,
        output mem_resp_rdy,
        output out_data_val, out_data, out_data_last, out_data_padbytes, out_data_srcid,
        input  out_data_rdy
    );

    modport master (
        output src_req_val, src_req_flowid, src_req_offset, src_req_size,
        input  src_req_rdy,
        input  mem_req_val, mem_req_addr, mem_req_size,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_data, mem_resp_last,
        input  mem_resp_rdy,
        input  out_data_val, out_data, out_data_last, out_data_padbytes, out_data_srcid,
        output out_data_rdy
    );
endinterface

// File: rtl/rd_circ_buf_multi.sv
// Multi-client circular-buffer read engine: round-robin grant, split of wrapping reads into
// two memory requests, and byte realignment of the second segment onto the first.
module rd_circ_buf_multi #(
    parameter int NUM_SRCS  = 2,
    parameter int DATA_W    = 512,
    parameter int BUF_PTR_W = 12,
    parameter int FLOW_ID_W = 8,
    parameter int SIZE_W    = 16,
    parameter int ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    rd_circ_buf_multi_if.slave bus
);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PAD_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int SRC_W      = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
    localparam logic [SIZE_W:0]   BUF_SIZE = {{SIZE_W{1'b0}}, 1'b1} << BUF_PTR_W;
    localparam logic [SIZE_W-1:0] DB_S     = SIZE_W'(DATA_BYTES);

    typedef enum logic [2:0] {IDLE, REQ0, REQ1, DATA, FLUSH, DRAIN} state_t;

    state_t                state_reg, state_next;
    logic [SRC_W-1:0]      rr_reg, rr_next;
    logic [FLOW_ID_W-1:0]  flowid_reg, flowid_next;
    logic [BUF_PTR_W-1:0]  offset_reg, offset_next;
    logic [SIZE_W-1:0]     size_reg, size_next;
    logic [SRC_W-1:0]      srcid_reg, srcid_next;
    logic [SIZE_W-1:0]     emit_left_reg, emit_left_next;
    logic                  in_seg1_reg, in_seg1_next;
    logic [DATA_W-1:0]     hold_reg, hold_next;
    logic                  out_val_reg, out_val_next;
    logic [DATA_W-1:0]     out_data_reg, out_data_next;
    logic                  out_last_reg, out_last_next;
    logic [PAD_W-1:0]      out_pad_reg, out_pad_next;
    logic [SRC_W-1:0]      out_srcid_reg, out_srcid_next;

    logic [FLOW_ID_W-1:0]  src_flowid [NUM_SRCS];
    logic [BUF_PTR_W-1:0]  src_offset [NUM_SRCS];
    logic [SIZE_W-1:0]     src_size   [NUM_SRCS];

    generate
        for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src
            assign src_flowid[gi] = bus.src_req_flowid[gi*FLOW_ID_W +: FLOW_ID_W];
            assign src_offset[gi] = bus.src_req_offset[gi*BUF_PTR_W +: BUF_PTR_W];
            assign src_size[gi]   = bus.src_req_size[gi*SIZE_W +: SIZE_W];
        end
    endgenerate

    logic [SIZE_W:0]     end_pos;
    logic                wrap;
    logic [SIZE_W-1:0]   seg0, seg1;
    logic [PAD_W-1:0]    r0;
    logic                shift;
    logic [ADDR_W-1:0]   base;
    logic                slot_free, last_beat;
    logic [PAD_W-1:0]    pad_val;
    logic [DATA_W-1:0]   keep_mask, hold_mask, resp_shifted, resp_tail;

    assign end_pos   = {1'b0, size_reg} + (SIZE_W+1)'(offset_reg);
    assign wrap      = end_pos > BUF_SIZE;
    assign seg0      = wrap ? SIZE_W'(BUF_SIZE - (SIZE_W+1)'(offset_reg)) : size_reg;
    assign seg1      = size_reg - seg0;
    assign r0        = PAD_W'(seg0 % DB_S);
    assign shift     = wrap && (r0 != '0);
    assign base      = BASE_ADDR + (ADDR_W'(flowid_reg) << BUF_PTR_W);
    assign slot_free = !out_val_reg || bus.out_data_rdy;
    assign last_beat = emit_left_reg <= DB_S;
    assign pad_val   = last_beat ? PAD_W'(DB_S - emit_left_reg) : '0;

    // Bytes are MSB-packed, so "first n bytes" is a mask of ones from the top.
    assign keep_mask    = last_beat ? ~({DATA_W{1'b1}} >> {emit_left_reg, 3'b000}) : '1;
    assign hold_mask    = ~({DATA_W{1'b1}} >> {r0, 3'b000});
    assign resp_shifted = hold_reg | (bus.mem_resp_data >> {r0, 3'b000});
    assign resp_tail    = bus.mem_resp_data << (DATA_W - 8*int'(r0));

    logic [NUM_SRCS-1:0] src_rdy;
    logic                mem_req_val, mem_resp_rdy;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [SIZE_W-1:0]   mem_req_size;
    logic                grant_found, emit;
    logic [SRC_W-1:0]    grant_idx, cand;
    logic [DATA_W-1:0]   emit_beat;

    always_comb begin
        state_next     = state_reg;
        rr_next        = rr_reg;
        flowid_next    = flowid_reg;
        offset_next    = offset_reg;
        size_next      = size_reg;
        srcid_next     = srcid_reg;
        emit_left_next = emit_left_reg;
        in_seg1_next   = in_seg1_reg;
        hold_next      = hold_reg;
        out_val_next   = out_val_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        out_pad_next   = out_pad_reg;
        out_srcid_next = out_srcid_reg;
        src_rdy        = '0;
        mem_req_val    = 1'b0;
        mem_req_addr   = '0;
        mem_req_size   = '0;
        mem_resp_rdy   = 1'b0;
        grant_found    = 1'b0;
        grant_idx      = '0;
        cand           = '0;
        emit           = 1'b0;
        emit_beat      = '0;

        for (int k = 0; k < NUM_SRCS; k++) begin
            cand = SRC_W'((int'(rr_reg) + k) % NUM_SRCS);
            if (!grant_found && bus.src_req_val[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        if (out_val_reg && bus.out_data_rdy) begin
            out_val_next  = 1'b0;
            out_last_next = 1'b0;
            out_pad_next  = '0;
        end

        case (state_reg)
            IDLE: if (grant_found) begin
                src_rdy[grant_idx] = 1'b1;
                flowid_next    = src_flowid[grant_idx];
                offset_next    = src_offset[grant_idx];
                size_next      = src_size[grant_idx];
                srcid_next     = grant_idx;
                emit_left_next = src_size[grant_idx];
                in_seg1_next   = 1'b0;
                hold_next      = '0;
                rr_next        = SRC_W'((int'(grant_idx) + 1) % NUM_SRCS);
                if (src_size[grant_idx] != '0)
                    state_next = REQ0;
            end
            REQ0: begin
                mem_req_val  = 1'b1;
                mem_req_addr = base + ADDR_W'(offset_reg);
                mem_req_size = seg0;
                if (bus.mem_req_rdy)
                    state_next = wrap ? REQ1 : DATA;
            end
            REQ1: begin
                mem_req_val  = 1'b1;
                mem_req_addr = base;
                mem_req_size = seg1;
                if (bus.mem_req_rdy)
                    state_next = DATA;
            end
            DATA: begin
                mem_resp_rdy = slot_free;
                if (slot_free && bus.mem_resp_val) begin
                    if (!in_seg1_reg) begin
                        if (bus.mem_resp_last && wrap)
                            in_seg1_next = 1'b1;
                        // A partial final seg0 beat is parked until seg1 bytes can fill it.
                        if (bus.mem_resp_last && shift) begin
                            hold_next = bus.mem_resp_data & hold_mask;
                        end else begin
                            emit      = 1'b1;
                            emit_beat = bus.mem_resp_data;
                        end
                    end else if (shift) begin
                        emit      = 1'b1;
                        emit_beat = resp_shifted;
                        hold_next = resp_tail;
                    end else begin
                        emit      = 1'b1;
                        emit_beat = bus.mem_resp_data;
                    end
                    if (emit) begin
                        if (last_beat)
                            state_next = DRAIN;
                        else if (bus.mem_resp_last && in_seg1_reg)
                            state_next = FLUSH;
                    end
                end
            end
            FLUSH: if (slot_free) begin
                emit       = 1'b1;
                emit_beat  = hold_reg;
                state_next = DRAIN;
            end
            DRAIN: if (out_val_reg && bus.out_data_rdy)
                state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (emit) begin
            out_val_next   = 1'b1;
            out_data_next  = emit_beat & keep_mask;
            out_last_next  = last_beat;
            out_pad_next   = pad_val;
            out_srcid_next = srcid_reg;
            emit_left_next = last_beat ? '0 : emit_left_reg - DB_S;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rr_reg        <= '0;
            flowid_reg    <= '0;
            offset_reg    <= '0;
            size_reg      <= '0;
            srcid_reg     <= '0;
            emit_left_reg <= '0;
            in_seg1_reg   <= 1'b0;
            hold_reg      <= '0;
            out_val_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_pad_reg   <= '0;
            out_srcid_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_reg        <= rr_next;
            flowid_reg    <= flowid_next;
            offset_reg    <= offset_next;
            size_reg      <= size_next;
            srcid_reg     <= srcid_next;
            emit_left_reg <= emit_left_next;
            in_seg1_reg   <= in_seg1_next;
            hold_reg      <= hold_next;
            out_val_reg   <= out_val_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            out_pad_reg   <= out_pad_next;
            out_srcid_reg <= out_srcid_next;
        end
    end

    assign bus.src_req_rdy       = src_rdy;
    assign bus.mem_req_val       = mem_req_val;
    assign bus.mem_req_addr      = mem_req_addr;
    assign bus.mem_req_size      = mem_req_size;
    assign bus.mem_resp_rdy      = mem_resp_rdy;
    assign bus.out_data_val      = out_val_reg;
    assign bus.out_data          = out_data_reg;
    assign bus.out_data_last     = out_last_reg;
    assign bus.out_data_padbytes = out_pad_reg;
    assign bus.out_data_srcid    = out_srcid_reg;
endmodule
